jtcop_obj_dma: RTL

- Parametrised object-RAM block with DMA copy into a display-side sprite table buffer.
- CPU writes the object RAM at any time. An `obj_copy` request snapshots it into a display buffer that the sprite renderer reads.
- Generalises the single fixed buffer to:
  - configurable depth;
  - single or ping-pong display buffers (`NBUF`);
  - immediate or blank-deferred copy (`DEFER`).
- Sits between the CPU bus decoder and the object line renderer.

---
 rtl/jtcop_objdma_pkg.sv | 15 +
 rtl/jtcop_objdma_ctrl.sv | 98 +++++++++
 rtl/jtcop_obj_dma.sv | 102 ++++++++++
 3 files changed

// File: rtl/jtcop_objdma_pkg.sv
// Shared types for the object-RAM DMA block: copy FSM states and the
// read-to-write delay of the copy datapath.
package jtcop_objdma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    COPY  = 2'd2,
    FLUSH = 2'd3
  } state_e;

  // Object RAM read data lands one clock after its address is issued.
  localparam int WR_DLY = 1;

endpackage

// File: rtl/jtcop_objdma_ctrl.sv
// Copy controller: obj_copy edge detect, pending request, copy FSM,
// word address counter and front/back display buffer select.
module jtcop_objdma_ctrl
  import jtcop_objdma_pkg::*;
#(
  parameter int AW    = 10,
  parameter int NBUF  = 1,
  parameter int DEFER = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          LVBL,
  input  logic          obj_copy,
  output logic          rd_en_o,
  output logic [AW-1:0] rd_addr_o,
  output logic          wr_en_o,
  output logic [AW-1:0] wr_addr_o,
  output logic          back_o,
  output logic          front_o,
  output logic          busy_o,
  output logic          done_o
);

  state_e        state_q, state_d;
  logic          copy_q;
  logic          pend_q, pend_d;
  logic          front_q;
  logic          done_q;
  logic          vld_p1;
  logic [AW-1:0] n_q;
  logic          trig;
  logic          hold;
  logic          issue;

  assign trig = obj_copy & ~copy_q;
  assign hold = (DEFER != 0) && LVBL;

  always_comb begin
    state_d = state_q;
    pend_d  = pend_q | trig;
    issue   = 1'b0;
    unique case (state_q)
      IDLE: begin
        // A trigger landing on the same clock the copy starts collapses into it.
        if (pend_q) begin
          pend_d  = 1'b0;
          state_d = hold ? WAIT : COPY;
        end
      end
      WAIT: begin
        if (!LVBL) begin
          issue   = cen;
          state_d = COPY;
        end
      end
      COPY: begin
        if (!hold && cen) begin
          issue = 1'b1;
          if (n_q == '1) state_d = FLUSH;
        end
      end
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      copy_q  <= 1'b0;
      pend_q  <= 1'b0;
      n_q     <= '0;
      vld_p1  <= 1'b0;
      done_q  <= 1'b0;
      front_q <= 1'b0;
    end else begin
      state_q <= state_d;
      copy_q  <= obj_copy;
      pend_q  <= pend_d;
      vld_p1  <= issue;
      done_q  <= (state_q == FLUSH);
      if (issue) n_q <= n_q + 1'b1;
      if (state_q == FLUSH && NBUF == 2) front_q <= ~front_q;
    end
  end

  assign rd_en_o   = issue;
  assign rd_addr_o = n_q;
  // The counter has already advanced past the word now in flight.
  assign wr_addr_o = n_q - AW'(WR_DLY);
  assign wr_en_o   = vld_p1;
  assign back_o    = (NBUF == 2) ? ~front_q : front_q;
  assign front_o   = front_q;
  assign busy_o    = (state_q != IDLE) | pend_q;
  assign done_o    = done_q;

endmodule

// File: rtl/jtcop_obj_dma.sv
// Object RAM with DMA snapshot into single or ping-pong display buffers.
// Optional copy counter on dbg_copies enabled by `define JTCOP_OBJDMA_DBG_EN.
module jtcop_obj_dma
  import jtcop_objdma_pkg::*;
#(
  parameter int AW    = 10,
  parameter int NBUF  = 1,
  parameter int DEFER = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          LVBL,
  input  logic [AW-1:0] cpu_addr,
  input  logic [15:0]   cpu_dout,
  input  logic [1:0]    cpu_dsn,
  input  logic          cpu_we,
  output logic [15:0]   obj_dout,
  input  logic          obj_copy,
  input  logic [AW-1:0] rd_addr,
  output logic [15:0]   rd_data,
  output logic          busy,
  output logic          done,
  output logic [7:0]    dbg_copies
);

  logic [15:0]   obj_mem [2**AW];
  // Both halves exist for any NBUF; with NBUF=1 the select stays 0 and the upper half is never touched.
  logic [15:0]   buf_mem [2**(AW+1)];
  logic [15:0]   obj_dout_q;
  logic [15:0]   rd_data_q;
  logic [15:0]   dma_p1;
  logic          dma_rd;
  logic [AW-1:0] dma_addr;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic          back_sel;
  logic          front_sel;

  jtcop_objdma_ctrl #(
    .AW    (AW),
    .NBUF  (NBUF),
    .DEFER (DEFER)
  ) u_ctrl (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .LVBL      (LVBL),
    .obj_copy  (obj_copy),
    .rd_en_o   (dma_rd),
    .rd_addr_o (dma_addr),
    .wr_en_o   (wr_en),
    .wr_addr_o (wr_addr),
    .back_o    (back_sel),
    .front_o   (front_sel),
    .busy_o    (busy),
    .done_o    (done)
  );

  always_ff @(posedge clk) begin
    if (cpu_we) begin
      if (!cpu_dsn[1]) obj_mem[cpu_addr][15:8] <= cpu_dout[15:8];
      if (!cpu_dsn[0]) obj_mem[cpu_addr][7:0]  <= cpu_dout[7:0];
    end
  end

  // p1: word fetched from object RAM, written to the back buffer next clock
  always_ff @(posedge clk) begin
    if (dma_rd) dma_p1 <= obj_mem[dma_addr];
  end

  always_ff @(posedge clk) begin
    if (wr_en) buf_mem[{back_sel, wr_addr}] <= dma_p1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      obj_dout_q <= 16'd0;
      rd_data_q  <= 16'd0;
    end else begin
      obj_dout_q <= obj_mem[cpu_addr];
      rd_data_q  <= buf_mem[{front_sel, rd_addr}];
    end
  end

  assign obj_dout = obj_dout_q;
  assign rd_data  = rd_data_q;

`ifdef JTCOP_OBJDMA_DBG_EN
  logic [7:0] dbg_q;

  always_ff @(posedge clk) begin
    if (rst)       dbg_q <= 8'd0;
    else if (done) dbg_q <= dbg_q + 8'd1;
  end

  assign dbg_copies = dbg_q;
`else
  assign dbg_copies = 8'd0;
`endif

endmodule
